pe_psum_accumulator: RTL and testbench

- Sits directly downstream of the 8x8 signed Baugh-Wooley multiplier inside each systolic-array PE.
- Consumes the signed product stream and sign-extends each product to the accumulator width.
- Accumulates the products over one context, optionally with saturation.
- Hands the finished partial sum to the PE output chain through a single-entry valid/ready buffer.

---
 rtl/pe_psum_accumulator_if.sv | 37 +++
 rtl/pe_psum_accumulator.sv | 145 ++++++++++++++
 tb/tb_pe_psum_accumulator.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_psum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_psum_accumulator_if
// Description : Product-stream input and partial-sum output bundle of the
//               PE partial-sum accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_psum_accumulator_if #(
   parameter int MAC_OUT_WIDTH = 16,
   parameter int ACC_WIDTH     = 24
);
   logic                     i_en_ff;
   logic                     i_mul_valid;
   logic [MAC_OUT_WIDTH-1:0] i_mul_res;
   logic                     i_mul_clear;
   logic                     i_mul_last;
   logic                     o_mul_ready;
   logic                     i_sat_en;
   logic                     o_psum_valid;
   logic [ACC_WIDTH-1:0]     o_psum;
   logic                     o_psum_ovf;
   logic                     i_psum_ready;
   logic                     o_busy;

   modport master (
      output i_en_ff, i_mul_valid, i_mul_res, i_mul_clear, i_mul_last,
             i_sat_en, i_psum_ready,
      input  o_mul_ready, o_psum_valid, o_psum, o_psum_ovf, o_busy
   );

   modport slave (
      input  i_en_ff, i_mul_valid, i_mul_res, i_mul_clear, i_mul_last,
             i_sat_en, i_psum_ready,
      output o_mul_ready, o_psum_valid, o_psum, o_psum_ovf, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/pe_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : pe_psum_accumulator
// Description : Sign-extends the PE product stream, accumulates it per
//               context (wrap or saturate) and hands finished sums to a
//               single-entry valid/ready output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_psum_accumulator #(
   parameter int MAC_OUT_WIDTH = 16,
   parameter int ACC_WIDTH     = 24
) (
   input wire                  i_clk,
   input wire                  i_rst,
   pe_psum_accumulator_if.slave bus
);

   localparam logic [ACC_WIDTH-1:0] c_sat_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] c_sat_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCUM    = 2'd1,
      ST_WAIT_OUT = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   logic                   r_s1_valid;
   logic [ACC_WIDTH-1:0]   r_s1_data;
   logic                   r_s1_clear;
   logic                   r_s1_last;

   logic [ACC_WIDTH-1:0]   r_acc;
   logic                   r_ovf_sticky;

   logic                   r_out_valid;
   logic [ACC_WIDTH-1:0]   r_out_psum;
   logic                   r_out_ovf;

   logic                   w_drain;
   logic                   w_blocked;
   logic                   w_consume;
   logic                   w_mul_ready;
   logic                   w_accept;
   logic                   w_start;
   logic [ACC_WIDTH-1:0]   w_base;
   logic [ACC_WIDTH:0]     w_sum_ext;
   logic                   w_ovf;
   logic [ACC_WIDTH-1:0]   w_sum;
   logic                   w_ovf_next;

   assign w_drain     = r_out_valid & bus.i_psum_ready & bus.i_en_ff;
   // A last beat may only retire into the buffer if the buffer is free or
   // is being emptied on the same edge.
   assign w_blocked   = r_s1_valid & r_s1_last & r_out_valid & ~bus.i_psum_ready;
   assign w_consume   = bus.i_en_ff & r_s1_valid & ~w_blocked;
   assign w_mul_ready = ~i_rst & bus.i_en_ff & (~r_s1_valid | w_consume);
   assign w_accept    = bus.i_mul_valid & w_mul_ready;

   // Leaving a context (IDLE) makes the next beat start fresh even without clear.
   assign w_start    = r_s1_clear | (r_state == ST_IDLE);
   assign w_base     = w_start ? '0 : r_acc;
   assign w_sum_ext  = {w_base[ACC_WIDTH-1], w_base} + {r_s1_data[ACC_WIDTH-1], r_s1_data};
   assign w_ovf      = w_sum_ext[ACC_WIDTH] ^ w_sum_ext[ACC_WIDTH-1];
   assign w_ovf_next = w_ovf | (~w_start & r_ovf_sticky);

   always_comb begin
      w_sum = w_sum_ext[ACC_WIDTH-1:0];
      if (w_ovf && bus.i_sat_en) begin
         w_sum = w_sum_ext[ACC_WIDTH] ? c_sat_min : c_sat_max;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (bus.i_en_ff && r_s1_valid) begin
         if (w_blocked) begin
            w_state_next = ST_WAIT_OUT;
         end else if (r_s1_last) begin
            w_state_next = ST_IDLE;
         end else begin
            w_state_next = ST_ACCUM;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_data    <= '0;
         r_s1_clear   <= 1'b0;
         r_s1_last    <= 1'b0;
         r_acc        <= '0;
         r_ovf_sticky <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_psum   <= '0;
         r_out_ovf    <= 1'b0;
      end else if (bus.i_en_ff) begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= {{(ACC_WIDTH-MAC_OUT_WIDTH){bus.i_mul_res[MAC_OUT_WIDTH-1]}},
                           bus.i_mul_res};
            r_s1_clear <= bus.i_mul_clear;
            r_s1_last  <= bus.i_mul_last;
         end else if (w_consume) begin
            r_s1_valid <= 1'b0;
         end

         if (w_drain) begin
            r_out_valid <= 1'b0;
         end

         if (w_consume) begin
            if (r_s1_last) begin
               r_out_valid  <= 1'b1;
               r_out_psum   <= w_sum;
               r_out_ovf    <= w_ovf_next;
               r_acc        <= '0;
               r_ovf_sticky <= 1'b0;
            end else begin
               r_acc        <= w_sum;
               r_ovf_sticky <= w_ovf_next;
            end
         end
      end
   end

   assign bus.o_mul_ready  = w_mul_ready;
   assign bus.o_psum_valid = r_out_valid;
   assign bus.o_psum       = r_out_psum;
   assign bus.o_psum_ovf   = r_out_ovf;
   assign bus.o_busy       = (r_state != ST_IDLE) | r_s1_valid;

endmodule
`default_nettype wire

// File: tb/tb_pe_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_psum_accumulator
// Description : Directed bench for pe_psum_accumulator with a beat-level
//               arithmetic model and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_psum_accumulator;

   localparam int  MW      = 16;
   localparam int  AW      = 18;
   localparam int  ACC_MAX = 131071;
   localparam int  ACC_MIN = -131072;
   localparam int  ACC_MOD = 262144;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pe_psum_accumulator_if #(.MAC_OUT_WIDTH(MW), .ACC_WIDTH(AW)) bus ();

   pe_psum_accumulator #(.MAC_OUT_WIDTH(MW), .ACC_WIDTH(AW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int  checks = 0;
   int  passes = 0;
   int  cyc    = 0;

   int  exp_q[$];
   bit  exp_ovf_q[$];
   int  drained_q[$];
   bit  drained_ovf_q[$];
   int  drain_cyc_q[$];
   int  accept_last_cyc = 0;

   longint m_acc    = 0;
   bit     m_in_ctx = 1'b0;
   bit     m_sticky = 1'b0;

   function automatic void check(string name, longint act, longint req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endfunction

   // Context arithmetic straight from the accumulate rules, on plain integers.
   function automatic void model_beat(int v, bit c, bit l, bit sat);
      bit     start;
      longint s;
      bit     ovf;
      start = c || !m_in_ctx;
      s     = (start ? 0 : m_acc) + v;
      ovf   = (s > ACC_MAX) || (s < ACC_MIN);
      if (ovf) begin
         if (sat) s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
         else     s = (s > ACC_MAX) ? s - ACC_MOD : s + ACC_MOD;
      end
      m_sticky = (start ? 1'b0 : m_sticky) | ovf;
      if (l) begin
         exp_q.push_back(int'(s));
         exp_ovf_q.push_back(m_sticky);
         m_acc    = 0;
         m_sticky = 1'b0;
         m_in_ctx = 1'b0;
      end else begin
         m_acc    = s;
         m_in_ctx = 1'b1;
      end
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         exp_ovf_q.delete();
         m_acc    = 0;
         m_sticky = 1'b0;
         m_in_ctx = 1'b0;
      end else begin
         if (bus.o_psum_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL psum_unexpected: got %0d, required no output",
                        $signed(bus.o_psum));
            end else begin
               check("psum_model", $signed(bus.o_psum), exp_q[0]);
               check("ovf_model", bus.o_psum_ovf, exp_ovf_q[0]);
               if (bus.i_psum_ready && bus.i_en_ff) begin
                  drained_q.push_back(int'($signed(bus.o_psum)));
                  drained_ovf_q.push_back(bus.o_psum_ovf);
                  drain_cyc_q.push_back(cyc);
                  void'(exp_q.pop_front());
                  void'(exp_ovf_q.pop_front());
               end
            end
         end
         if (bus.i_mul_valid && bus.o_mul_ready) begin
            model_beat(int'($signed(bus.i_mul_res)), bus.i_mul_clear,
                       bus.i_mul_last, bus.i_sat_en);
            if (bus.i_mul_last) accept_last_cyc = cyc;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic beat(input int v, input bit c, input bit l, output int waits);
      bus.i_mul_valid = 1'b1;
      bus.i_mul_res   = v[MW-1:0];
      bus.i_mul_clear = c;
      bus.i_mul_last  = l;
      waits = 0;
      @(negedge clk);
      while (!bus.o_mul_ready && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 40) begin
         checks++;
         $display("FAIL beat_timeout: got no accept in %0d cycles, required accept", waits);
      end
      @(posedge clk);
      #1;
      bus.i_mul_valid = 1'b0;
      bus.i_mul_clear = 1'b0;
      bus.i_mul_last  = 1'b0;
   endtask

   task automatic wait_drains(input int target);
      int n;
      n = 0;
      while (drained_q.size() < target && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (drained_q.size() < target) begin
         checks++;
         $display("FAIL drain_timeout: got %0d sums, required %0d", drained_q.size(), target);
      end
   endtask

   function automatic int drained_at(int idx);
      return (idx < drained_q.size()) ? drained_q[idx] : 32'h7fff_ffff;
   endfunction

   function automatic int dcyc_at(int idx);
      return (idx < drain_cyc_q.size()) ? drain_cyc_q[idx] : -1000;
   endfunction

   function automatic bit dovf_at(int idx);
      return (idx < drained_ovf_q.size()) ? drained_ovf_q[idx] : 1'bx;
   endfunction

   initial begin
      int w;
      int b;
      bus.i_en_ff      = 1'b1;
      bus.i_mul_valid  = 1'b0;
      bus.i_mul_res    = '0;
      bus.i_mul_clear  = 1'b0;
      bus.i_mul_last   = 1'b0;
      bus.i_sat_en     = 1'b0;
      bus.i_psum_ready = 1'b1;

      @(posedge clk);
      #1;
      check("rst_psum_valid", bus.o_psum_valid, 0);
      check("rst_psum", bus.o_psum, 0);
      check("rst_ovf", bus.o_psum_ovf, 0);
      check("rst_busy", bus.o_busy, 0);
      check("rst_mul_ready", bus.o_mul_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic accumulate: 3 - 5 + 100
      b = drained_q.size();
      beat(3, 1'b1, 1'b0, w);
      beat(-5, 1'b0, 1'b0, w);
      beat(100, 1'b0, 1'b1, w);
      wait_drains(b + 1);
      check("basic_sum", drained_at(b), 98);
      check("basic_ovf", dovf_at(b), 0);
      check("basic_latency", dcyc_at(b) - accept_last_cyc, 2);
      @(negedge clk);
      check("basic_one_wide", bus.o_psum_valid, 0);

      // Single-beat contexts back to back
      @(posedge clk);
      #1;
      b = drained_q.size();
      beat(-7, 1'b1, 1'b1, w);
      check("b2b_ready0", w, 0);
      beat(12, 1'b1, 1'b1, w);
      check("b2b_ready1", w, 0);
      beat(-16384, 1'b1, 1'b1, w);
      check("b2b_ready2", w, 0);
      wait_drains(b + 3);
      check("b2b_sum0", drained_at(b), -7);
      check("b2b_sum1", drained_at(b + 1), 12);
      check("b2b_sum2", drained_at(b + 2), -16384);
      check("b2b_consec0", dcyc_at(b + 1) - dcyc_at(b), 1);
      check("b2b_consec1", dcyc_at(b + 2) - dcyc_at(b + 1), 1);

      // Back-pressure: A = 1,2 held; B = 10,20 blocks on its last beat
      @(posedge clk);
      #1;
      bus.i_psum_ready = 1'b0;
      b = drained_q.size();
      beat(1, 1'b1, 1'b0, w);
      beat(2, 1'b0, 1'b1, w);
      beat(10, 1'b1, 1'b0, w);
      beat(20, 1'b0, 1'b1, w);
      repeat (3) @(negedge clk);
      #1;
      check("bp_mul_ready_low", bus.o_mul_ready, 0);
      check("bp_held_valid", bus.o_psum_valid, 1);
      check("bp_held_psum", $signed(bus.o_psum), 3);
      check("bp_busy", bus.o_busy, 1);
      @(posedge clk);
      #1;
      bus.i_psum_ready = 1'b1;
      wait_drains(b + 2);
      check("bp_sum_a", drained_at(b), 3);
      check("bp_sum_b", drained_at(b + 1), 30);
      check("bp_consec", dcyc_at(b + 1) - dcyc_at(b), 1);
      repeat (3) @(negedge clk);
      check("bp_no_dup", drained_q.size(), b + 2);

      // Saturation: nine times 16384 overflows 18 bits
      @(posedge clk);
      #1;
      bus.i_sat_en = 1'b1;
      b = drained_q.size();
      for (int i = 0; i < 9; i++) beat(16384, i == 0, i == 8, w);
      wait_drains(b + 1);
      check("sat_sum", drained_at(b), 131071);
      check("sat_ovf", dovf_at(b), 1);
      @(posedge clk);
      #1;
      bus.i_sat_en = 1'b0;
      for (int i = 0; i < 9; i++) beat(16384, i == 0, i == 8, w);
      wait_drains(b + 2);
      check("wrap_sum", drained_at(b + 1), -114688);
      check("wrap_ovf", dovf_at(b + 1), 1);
      @(posedge clk);
      #1;
      beat(5, 1'b1, 1'b1, w);
      wait_drains(b + 3);
      check("after_ovf_sum", drained_at(b + 2), 5);
      check("after_ovf_flag", dovf_at(b + 2), 0);

      // Enable stall mid-context
      @(posedge clk);
      #1;
      b = drained_q.size();
      beat(10, 1'b1, 1'b0, w);
      beat(20, 1'b0, 1'b0, w);
      bus.i_en_ff = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_mul_ready", bus.o_mul_ready, 0);
      end
      @(posedge clk);
      #1;
      bus.i_en_ff = 1'b1;
      beat(30, 1'b0, 1'b1, w);
      wait_drains(b + 1);
      check("stall_sum", drained_at(b), 60);

      // Async reset with a full output buffer and an open context
      @(posedge clk);
      #1;
      bus.i_psum_ready = 1'b0;
      beat(7, 1'b1, 1'b1, w);
      beat(5, 1'b1, 1'b0, w);
      check("pre_rst_valid", bus.o_psum_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_psum_valid", bus.o_psum_valid, 0);
      check("arst_psum", bus.o_psum, 0);
      check("arst_ovf", bus.o_psum_ovf, 0);
      check("arst_busy", bus.o_busy, 0);
      check("arst_mul_ready", bus.o_mul_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_psum_ready = 1'b1;
      b = drained_q.size();
      beat(4, 1'b0, 1'b1, w);
      wait_drains(b + 1);
      check("post_rst_sum", drained_at(b), 4);
      check("post_rst_ovf", dovf_at(b), 0);
      repeat (3) @(negedge clk);
      check("post_rst_no_stale", drained_q.size(), b + 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000 ns, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
